// File: rtl/div_unit_if.sv
// Divider request/response bundle.
// Control side drives start/operands, divider returns status/results.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             iStart;
  logic             iSigned;
  logic [WIDTH-1:0] iDividend;
  logic [WIDTH-1:0] iDivisor;
  logic             oBusy;
  logic             oDone;
  logic [WIDTH-1:0] oQuot;
  logic [WIDTH-1:0] oRem;
  logic             oDivZero;

  modport master (
    output iStart, iSigned, iDividend, iDivisor,
    input  oBusy, oDone, oQuot, oRem, oDivZero
  );

  modport slave (
    input  iStart, iSigned, iDividend, iDivisor,
    output oBusy, oDone, oQuot, oRem, oDivZero
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU.
// One quotient bit per cycle, sign fix-up on entry to DONE.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic     iClk,
  input  logic     iRstN,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_accept;
  logic   w_last;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_dend;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;

  logic [WIDTH-1:0] r_oquot;
  logic [WIDTH-1:0] r_orem;
  logic             r_odz;

  logic             w_dend_neg;
  logic             w_dvsr_neg;
  logic [WIDTH-1:0] w_dend_mag;
  logic [WIDTH-1:0] w_dvsr_mag;
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_trial;
  logic             w_ge;
  logic [WIDTH:0]   w_rem_nx;
  logic [WIDTH-1:0] w_quot_nx;
  logic [WIDTH-1:0] w_fq;
  logic [WIDTH-1:0] w_fr;

  assign w_dend_neg = bus.iSigned & bus.iDividend[WIDTH-1];
  assign w_dvsr_neg = bus.iSigned & bus.iDivisor[WIDTH-1];
  assign w_dend_mag = w_dend_neg ? -bus.iDividend : bus.iDividend;
  assign w_dvsr_mag = w_dvsr_neg ? -bus.iDivisor : bus.iDivisor;

  // Shift next dividend bit in, then trial-subtract the divisor.
  assign w_shift   = {r_rem, r_quot[WIDTH-1]};
  assign w_trial   = w_shift - {2'b00, r_dvsr};
  assign w_ge      = ~w_trial[WIDTH+1];
  assign w_rem_nx  = w_ge ? w_trial[WIDTH:0] : w_shift[WIDTH:0];
  assign w_quot_nx = {r_quot[WIDTH-2:0], w_ge};

  // Divide-by-zero overrides; 0x8000_0000/-1 falls out naturally.
  always_comb begin
    w_fq = r_neg_q ? -w_quot_nx : w_quot_nx;
    w_fr = r_neg_r ? -w_rem_nx[WIDTH-1:0] : w_rem_nx[WIDTH-1:0];
    if (r_dz) begin
      w_fq = '1;
      w_fr = r_dend;
    end
  end

  // State register.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and start acceptance.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.iStart) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == LAST) begin
          w_last = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.iStart) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture and one iteration per RUN cycle.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quot  <= '0;
      r_dvsr  <= '0;
      r_dend  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quot  <= w_dend_mag;
      r_dvsr  <= w_dvsr_mag;
      r_dend  <= bus.iDividend;
      r_neg_q <= w_dend_neg ^ w_dvsr_neg;
      r_neg_r <= w_dend_neg;
      r_dz    <= (bus.iDivisor == '0);
    end else if (r_state == S_RUN) begin
      r_cnt  <= r_cnt + 1'b1;
      r_rem  <= w_rem_nx;
      r_quot <= w_quot_nx;
    end
  end

  // Results load only on entry to DONE and hold otherwise.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_oquot <= '0;
      r_orem  <= '0;
      r_odz   <= 1'b0;
    end else if (w_last) begin
      r_oquot <= w_fq;
      r_orem  <= w_fr;
      r_odz   <= r_dz;
    end
  end

  assign bus.oBusy    = (r_state == S_RUN);
  assign bus.oDone    = (r_state == S_DONE);
  assign bus.oQuot    = r_oquot;
  assign bus.oRem     = r_orem;
  assign bus.oDivZero = r_odz;
endmodule
